// File: rtl/instr_packer.sv
// Packs RV32 I/S/B/R instruction fields into 32-bit words and queues them with a byte address.
// Optional macro INSTR_PACKER_RANGE_CHECK_EN enables immediate range checking and the err_o flag.
module instr_packer #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [12:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        err_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        FmtI = 2'b00,
        FmtS = 2'b01,
        FmtB = 2'b10,
        FmtR = 2'b11
    } fmt_e;

    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     addr_q, addr_d;

    logic            push;
    logic            pop;
    logic            enq;
    logic            imm_bad;
    logic [31:0]     packed_word;

    always_comb begin
        packed_word = '0;
        unique case (fmt_e'(fmt_i))
            FmtI: packed_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FmtS: packed_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FmtB: packed_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                                 imm_i[4:1], imm_i[11], opcode_i};
            FmtR: packed_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            default: packed_word = '0;
        endcase
    end

`ifdef INSTR_PACKER_RANGE_CHECK_EN
    logic err_q, err_d;

    // I/S immediates must sign-fit 12 bits; B offsets must be halfword aligned.
    always_comb begin
        imm_bad = 1'b0;
        unique case (fmt_e'(fmt_i))
            FmtI, FmtS: imm_bad = imm_i[12] ^ imm_i[11];
            FmtB:       imm_bad = imm_i[0];
            default:    imm_bad = 1'b0;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (push && imm_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign imm_bad = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready_o  = (count_q < CntFull);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign enq         = push && !imm_bad;

    assign instr_o = out_valid_o ? mem_q[rd_ptr_q] : 32'h0;
    assign addr_o  = addr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            addr_d   = addr_q + 32'd4;
        end
        unique case ({enq, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
        end
    end

    // Storage needs no reset: instr_o is gated off whenever the queue is empty.
    always_ff @(posedge clk_i) begin
        if (rst_i && enq) begin
            mem_q[wr_ptr_q] <= packed_word;
        end
    end

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer: scoreboard of expected words, checked as the DUT pops them.
module tb_instr_packer;

    localparam int unsigned Depth = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = 32'h0;
    logic        exp_err  = 1'b0;

    instr_packer #(
        .FIFO_DEPTH(Depth)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .fmt_i      (fmt),
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .funct7_i   (funct7),
        .rd_i       (rd),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .imm_i      (imm),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .instr_o    (instr),
        .addr_o     (addr),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: places each field at its architectural bit position.
    function automatic logic [31:0] model_pack(input logic [1:0] f, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [12:0] im);
        logic [31:0] w;
        w        = 32'h0;
        w[6:0]   = op;
        w[14:12] = f3;
        w[19:15] = s1;
        case (f)
            2'd0: begin
                w[11:7]  = d;
                w[31:20] = im[11:0];
            end
            2'd1: begin
                w[11:7]  = im[4:0];
                w[24:20] = s2;
                w[31:25] = im[11:5];
            end
            2'd2: begin
                w[7]     = im[11];
                w[11:8]  = im[4:1];
                w[24:20] = s2;
                w[30:25] = im[10:5];
                w[31]    = im[12];
            end
            default: begin
                w[11:7]  = d;
                w[24:20] = s2;
                w[31:25] = f7;
            end
        endcase
        return w;
    endfunction

    function automatic logic model_bad(input logic [1:0] f, input logic [12:0] im);
`ifdef INSTR_PACKER_RANGE_CHECK_EN
        if (f == 2'd0 || f == 2'd1) return im[12] != im[11];
        if (f == 2'd2) return im[0];
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_state();
        check("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
        check("in_ready", {31'h0, in_ready}, {31'h0, exp_q.size() < Depth});
        check("err", {31'h0, err}, {31'h0, exp_err});
        check("addr", addr, exp_addr);
        if (exp_q.size() != 0) check("head_instr", instr, exp_q[0]);
        else check("empty_instr", instr, 32'h0);
    endtask

    task automatic drive(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [12:0] im);
        in_valid = 1'b1;
        fmt      = f;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        imm      = im;
    endtask

    // One clock: decide handshakes from settled signals, step the model at the edge,
    // then check the DUT state at the following falling edge.
    task automatic tick();
        logic push_fire;
        logic pop_fire;
        #1;
        push_fire = rst_n && in_valid && in_ready;
        pop_fire  = rst_n && out_valid && out_ready;
        if (pop_fire && exp_q.size() != 0) begin
            check("pop_instr", instr, exp_q[0]);
            check("pop_addr", addr, exp_addr);
        end
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            exp_addr = 32'h0;
            exp_err  = 1'b0;
        end else begin
            if (pop_fire && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                exp_addr = exp_addr + 32'd4;
            end
            if (push_fire) begin
                if (model_bad(fmt, imm)) exp_err = 1'b1;
                else exp_q.push_back(model_pack(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm));
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(2'd0, 7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 13'h0);
        in_valid = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);

        // I-type with all-ones immediate, visible one cycle after acceptance
        drive(2'd0, 7'b0010011, 3'b000, 7'h0, 5'd1, 5'd0, 5'd0, 13'h1FFF);
        tick();
        in_valid = 1'b0;
        check("i_word", instr, 32'hFFF00093);
        check("i_addr", addr, 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        drive(2'd1, 7'b0100011, 3'b010, 7'h0, 5'd0, 5'd0, 5'd2, 13'd8);
        tick();
        in_valid = 1'b0;
        check("s_word", instr, 32'h00202423);
        check("s_addr", addr, 32'h4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        drive(2'd2, 7'b1100011, 3'b000, 7'h0, 5'd0, 5'd0, 5'd0, 13'h1FFC);
        tick();
        in_valid = 1'b0;
        check("b_word", instr, 32'hFE000EE3);
        check("b_addr", addr, 32'h8);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        drive(2'd3, 7'b0110011, 3'b101, 7'b0100000, 5'd7, 5'd9, 5'd31, 13'h0AAA);
        tick();
        in_valid = 1'b0;
        check("r_word", instr, 32'h41F4D3B3);
        out_ready = 1'b1;
        tick();

        // Mixed traffic with concurrent push/pop
        for (int i = 0; i < 40; i++) begin
            drive(2'($urandom_range(0, 3)), 7'($urandom), 3'($urandom), 7'($urandom),
                  5'($urandom), 5'($urandom), 5'($urandom), 13'($urandom));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("drained", {31'h0, out_valid}, 32'h0);

        // Backpressure: third push must wait until a slot frees after the pop cycle
        do_reset();
        out_ready = 1'b0;
        drive(2'd0, 7'h13, 3'd0, 7'h0, 5'd1, 5'd2, 5'd0, 13'h0011);
        tick();
        drive(2'd0, 7'h13, 3'd0, 7'h0, 5'd3, 5'd4, 5'd0, 13'h0022);
        tick();
        check("full_ready", {31'h0, in_ready}, 32'h0);
        drive(2'd0, 7'h13, 3'd0, 7'h0, 5'd5, 5'd6, 5'd0, 13'h0033);
        tick();
        check("full_hold_ready", {31'h0, in_ready}, 32'h0);
        check("full_hold_head", instr, 32'h01110093);
        out_ready = 1'b1;
        tick();
        check("after_pop_addr", addr, 32'h4);
        tick();
        in_valid = 1'b0;
        check("third_addr", addr, 32'h8);
        check("third_word", instr, 32'h03330293);
        tick();
        check("bp_drained", {31'h0, out_valid}, 32'h0);

        // Range-check behaviour of a misaligned branch
        out_ready = 1'b0;
        drive(2'd2, 7'h63, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, 13'h0003);
        tick();
        in_valid = 1'b0;
`ifdef INSTR_PACKER_RANGE_CHECK_EN
        check("bad_err", {31'h0, err}, 32'h1);
        check("bad_not_queued", {31'h0, out_valid}, 32'h0);
        tick();
        check("bad_err_sticky", {31'h0, err}, 32'h1);
`else
        check("bad_queued", {31'h0, out_valid}, 32'h1);
        check("bad_no_err", {31'h0, err}, 32'h0);
`endif
        do_reset();
        check("err_cleared", {31'h0, err}, 32'h0);

        // Mid-operation reset with two queued words and a coincident push/pop
        out_ready = 1'b0;
        drive(2'd0, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 13'h0001);
        tick();
        drive(2'd0, 7'h13, 3'd0, 7'h0, 5'd2, 5'd0, 5'd0, 13'h0002);
        tick();
        out_ready = 1'b1;
        addr_ready_pop_setup();
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_addr", addr, 32'h0);
        drive(2'd0, 7'h13, 3'd0, 7'h0, 5'd3, 5'd0, 5'd0, 13'h0003);
        tick();
        in_valid = 1'b0;
        check("post_rst_addr", addr, 32'h0);
        check("post_rst_word", instr, 32'h00300193);
        out_ready = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic addr_ready_pop_setup();
        drive(2'd3, 7'h33, 3'd0, 7'h0, 5'd4, 5'd5, 5'd6, 13'h0);
    endtask

endmodule

// File: doc/instr_packer.md
INSTR_PACKER -- requirements
Module: Instr_Packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output-queue entries (legal values 2 or 4).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports in_valid_i input 1 and in_ready_o output 1: field-side handshake.
REQ-005 SHALL have port fmt_i  input  2  instruction format: 00 I, 01 S, 10 B, 11 R.
REQ-006 SHALL have ports opcode_i input 7, funct3_i input 3, funct7_i input 7: instruction fields.
REQ-007 SHALL have ports rd_i, rs1_i, rs2_i, each input 5: register indices.
REQ-008 SHALL have port imm_i  input  13  signed immediate, two's complement.
REQ-009 SHALL have ports out_valid_o output 1 and out_ready_i input 1: word-side handshake.
REQ-010 SHALL have port instr_o  output  32  packed instruction at the queue head.
REQ-011 SHALL have port addr_o  output  32  byte address of the word at the queue head.
REQ-012 SHALL have port err_o  output  1  sticky immediate-range error flag.

Function
REQ-013 SHALL accept a field set when in_valid_i and in_ready_o are both 1 at a rising edge.
REQ-014 SHALL emit a word when out_valid_o and out_ready_i are both 1 at a rising edge.
REQ-015 SHALL pack I as {imm[11:0],rs1,funct3,rd,opcode}.
REQ-016 SHALL pack S as {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-017 SHALL pack B as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
REQ-018 SHALL pack R as {funct7,rs2,rs1,funct3,rd,opcode}; imm_i ignored.
REQ-019 SHALL make each accepted word visible on instr_o with out_valid_o=1 exactly one cycle after acceptance if the queue was empty; no combinational in-to-out path.
REQ-020 SHALL keep accepted words in FIFO order in a FIFO_DEPTH-entry circular queue with a registered occupancy count.
REQ-021 SHALL drive in_ready_o = 1 iff count < FIFO_DEPTH; when full, in_ready_o=0 even if a pop occurs in the same cycle.
REQ-022 SHALL, on simultaneous push and pop with count between 1 and FIFO_DEPTH-1, leave count unchanged and keep order.
REQ-023 SHALL drive out_valid_o = 1 iff count > 0; instr_o and addr_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-024 SHALL increment the address counter by 4 on each pop, wrapping from 0xFFFFFFFC to 0x00000000.
REQ-025 SHALL not pass x/undefined data out: instr_o SHALL read 0 when count = 0.

Reset
REQ-026 SHALL, while rst_i=0 at a rising edge, clear count, queue pointers and address counter to 0, and clear err_o.
REQ-027 SHALL drive in_ready_o=1, out_valid_o=0, instr_o=0, addr_o=0, err_o=0 in the cycle after reset.
REQ-028 SHALL discard all queued words on a mid-operation reset; a push or pop coincident with reset SHALL have no effect.

Configuration
REQ-029 SHALL use macro INSTR_PACKER_RANGE_CHECK_EN to compile immediate checking in or out.
REQ-030 With the macro defined, an I or S push with imm_i[12] != imm_i[11], or a B push with imm_i[0]=1, SHALL be consumed and not queued, and SHALL set err_o=1 the next cycle until reset.
REQ-031 With the macro undefined, err_o SHALL be tied to 0 and every accepted push SHALL be queued, truncating as per REQ-015 to REQ-017.

Verification
REQ-032 I push, opcode 0010011, funct3 000, rd 1, rs1 0, imm 13'h1FFF -> next cycle instr_o=0xFFF00093, addr_o=0.
REQ-033 S push, opcode 0100011, funct3 010, rs1 0, rs2 2, imm 8 -> instr_o=0x00202423.
REQ-034 B push, opcode 1100011, funct3 000, rs1 0, rs2 0, imm 13'h1FFC -> instr_o=0xFE000EE3.
REQ-035 Backpressure: FIFO_DEPTH=2, out_ready_i=0, three pushes -> in_ready_o=0 after the second; release -> words in order at addr_o 0, 4, 8.
REQ-036 Macro on: B push with imm 13'h0003 -> no word queued, err_o=1 next cycle; reset -> err_o=0.
REQ-037 Reset with two words queued -> out_valid_o=0, addr_o=0 next cycle; the next word pops at address 0.
